// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer.
// The optional lock timeout is enabled by defining PLL_SEQ_TIMEOUT_EN.
package pll_seq_pkg;

   localparam int NUM_DOMAINS = 3;
   localparam int LOST_CNT_W  = 8;

   typedef enum logic [2:0] {
      ST_PLL_RESET = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4
   } seq_state_t;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into refclk.
module pll_lock_sync (
   input  logic refclk,
   input  logic rst,
   input  logic locked,
   output logic locked_s
);

   logic meta;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         meta     <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         meta     <= locked;
         locked_s <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse, lock qualification and staggered per-domain reset release.
// Define PLL_SEQ_TIMEOUT_EN to retry the PLL when lock does not arrive in time.
//
// state        | meaning
// PLL_RESET    | pll_rst pulse, all domains held in reset
// WAIT_LOCK    | PLL running, waiting for synchronized lock
// STABLE       | lock seen, qualifying it for LOCK_STABLE_CYCLES
// RELEASE      | releasing domain resets one by one, RELEASE_GAP apart
// RUN          | all domains out of reset, ready
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 100000,
   parameter int RELEASE_GAP         = 8
) (
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   locked,
   input  logic                   relock_req,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                   ready,
   output logic [LOST_CNT_W-1:0]  lock_lost_count,
   output logic                   timeout_err
);

   localparam int RST_W = $clog2(RST_PULSE_CYCLES + 1);
   localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int REL_W = $clog2(2 * RELEASE_GAP + 1);
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_PULSE_CYCLES - 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [REL_W-1:0] REL_LAST = REL_W'((NUM_DOMAINS - 1) * RELEASE_GAP);

   seq_state_t             state, state_nxt;
   logic                   locked_s;
   logic                   go_reset;
   logic                   tmo_hit;
   logic [RST_W-1:0]       rst_cnt, rst_cnt_nxt;
   logic [STB_W-1:0]       stb_cnt, stb_cnt_nxt;
   logic [REL_W-1:0]       rel_cnt, rel_cnt_nxt;
   logic                   pll_rst_nxt, ready_nxt;
   logic [NUM_DOMAINS-1:0] domain_rst_nxt;
   logic [LOST_CNT_W-1:0]  lost_nxt;

   pll_lock_sync u_lock_sync (
      .refclk   (refclk),
      .rst      (rst),
      .locked   (locked),
      .locked_s (locked_s)
   );

   always_comb begin
      state_nxt = state;
      go_reset  = 1'b0;
      lost_nxt  = lock_lost_count;
      case (state)
         ST_PLL_RESET: begin
            if (rst_cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (relock_req)    go_reset  = 1'b1;
            else if (locked_s) state_nxt = ST_STABLE;
            else if (tmo_hit)  go_reset  = 1'b1;
         end
         ST_STABLE: begin
            if (relock_req)               go_reset  = 1'b1;
            else if (!locked_s)           state_nxt = ST_WAIT_LOCK;
            else if (stb_cnt == STB_LAST) state_nxt = ST_RELEASE;
         end
         ST_RELEASE, ST_RUN: begin
            // lock loss wins over a coincident relock so it is counted exactly once
            if (!locked_s) begin
               go_reset = 1'b1;
               if (lock_lost_count != '1) lost_nxt = lock_lost_count + LOST_CNT_W'(1);
            end else if (relock_req) begin
               go_reset = 1'b1;
            end else if (state == ST_RELEASE && rel_cnt == REL_LAST) begin
               state_nxt = ST_RUN;
            end
         end
         default: go_reset = 1'b1;
      endcase
      if (go_reset) state_nxt = ST_PLL_RESET;

      rst_cnt_nxt = '0;
      stb_cnt_nxt = '0;
      rel_cnt_nxt = '0;
      if (state_nxt == state) begin
         if (state == ST_PLL_RESET && rst_cnt != '1) rst_cnt_nxt = rst_cnt + RST_W'(1);
         if (state == ST_STABLE    && stb_cnt != '1) stb_cnt_nxt = stb_cnt + STB_W'(1);
         if (state == ST_RELEASE   && rel_cnt != '1) rel_cnt_nxt = rel_cnt + REL_W'(1);
      end

      pll_rst_nxt    = (state_nxt == ST_PLL_RESET);
      ready_nxt      = (state_nxt == ST_RUN);
      domain_rst_nxt = '1;
      if (state_nxt == ST_RUN) begin
         domain_rst_nxt = '0;
      end else if (state_nxt == ST_RELEASE) begin
         for (int i = 0; i < NUM_DOMAINS; i++)
            domain_rst_nxt[i] = (rel_cnt_nxt < REL_W'(i * RELEASE_GAP));
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state           <= ST_PLL_RESET;
         pll_rst         <= 1'b1;
         domain_rst      <= '1;
         ready           <= 1'b0;
         lock_lost_count <= '0;
         rst_cnt         <= '0;
         stb_cnt         <= '0;
         rel_cnt         <= '0;
      end else begin
         state           <= state_nxt;
         pll_rst         <= pll_rst_nxt;
         domain_rst      <= domain_rst_nxt;
         ready           <= ready_nxt;
         lock_lost_count <= lost_nxt;
         rst_cnt         <= rst_cnt_nxt;
         stb_cnt         <= stb_cnt_nxt;
         rel_cnt         <= rel_cnt_nxt;
      end
   end

`ifdef PLL_SEQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt;

   assign tmo_hit = (state == ST_WAIT_LOCK) && (tmo_cnt == TMO_LAST);

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state_nxt != state)
            tmo_cnt <= '0;
         else if (state == ST_WAIT_LOCK && tmo_cnt != '1)
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         if (tmo_hit && !relock_req && !locked_s) timeout_err <= 1'b1;
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16: pll_rst assertion length in refclk cycles, minimum 2.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 100000: maximum WAIT_LOCK dwell before PLL retry.
REQ-004 SHALL have parameter RELEASE_GAP, default 8: cycles between successive domain reset releases, minimum 1.
REQ-005 refclk  input  1  sole clock; PLL reference clock domain.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 locked  input  1  PLL lock, asynchronous to refclk.
REQ-008 relock_req  input  1  single-cycle request to restart the PLL.
REQ-009 pll_rst  output  1  drives PLL rst.
REQ-010 domain_rst  output  3  per-outclk reset, active-high; bit i serves outclk_i.
REQ-011 ready  output  1  high only in RUN.
REQ-012 lock_lost_count  output  8  saturating count of lock losses after release began.
REQ-013 timeout_err  output  1  sticky flag: lock timeout occurred.

Function
REQ-014 locked SHALL pass through a 2-flop synchronizer; locked_s is its output; all decisions use locked_s only.
REQ-015 FSM states: PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN; all outputs registered.
REQ-016 PLL_RESET: pll_rst=1, domain_rst=3'b111; after RST_PULSE_CYCLES cycles, go to WAIT_LOCK; the synchronizer is not cleared.
REQ-017 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE, with the stability counter at 0.
REQ-018 STABLE: locked_s=0 -> WAIT_LOCK (timeout counter restarts); LOCK_STABLE_CYCLES consecutive locked_s=1 -> RELEASE.
REQ-019 RELEASE: domain_rst[0] clears on entry, [1] after RELEASE_GAP cycles, [2] after 2*RELEASE_GAP cycles, then RUN next cycle.
REQ-020 RELEASE or RUN with locked_s=0: next cycle domain_rst=3'b111, ready=0, lock_lost_count+1 (saturating at 255), state PLL_RESET.
REQ-021 relock_req=1 in any state except PLL_RESET: -> PLL_RESET with domain_rst=3'b111; ignored in PLL_RESET.
REQ-022 Simultaneous lock loss and relock_req in RELEASE/RUN: single transition to PLL_RESET; lock_lost_count increments once.
REQ-023 Lock loss in WAIT_LOCK/STABLE SHALL NOT increment lock_lost_count.
REQ-024 Counters SHALL be sized $clog2(param+1); no wrap; each counter clears on every state entry.

Reset
REQ-025 rst=1 asynchronously forces state PLL_RESET, pll_rst=1, domain_rst=3'b111, ready=0, lock_lost_count=0, timeout_err=0, synchronizer=0, all counters=0.
REQ-026 Release of rst SHALL begin a full RST_PULSE_CYCLES pulse; reset mid-RELEASE re-asserts all domain_rst asynchronously.

Configuration
REQ-027 Macro PLL_SEQ_TIMEOUT_EN defined: WAIT_LOCK counting to LOCK_TIMEOUT_CYCLES sets timeout_err=1 and goes to PLL_RESET.
REQ-028 Macro PLL_SEQ_TIMEOUT_EN undefined: no timeout counter; WAIT_LOCK waits indefinitely; timeout_err tied 0.

Structure
REQ-029 Package pll_seq_pkg SHALL hold the state enum type, NUM_DOMAINS=3 and LOST_CNT_W=8.
REQ-030 Synchronizer SHALL be sub-module pll_lock_sync (2 flops, async reset to 0); the FSM and counters stay in the top.

Verification (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, RELEASE_GAP=2)
REQ-031 Release rst, hold locked=1 -> pll_rst high exactly 4 cycles; domain_rst clears bits 0,1,2 at 2-cycle spacing; ready=1; lock_lost_count=0.
REQ-032 In RUN, drop locked for 3 cycles -> domain_rst=3'b111 and ready=0 within 3 cycles; lock_lost_count=1; new 4-cycle pll_rst pulse.
REQ-033 locked toggles every 5 cycles -> never leaves WAIT_LOCK/STABLE; domain_rst stays 3'b111; lock_lost_count stays 0.
REQ-034 locked=0 permanently, PLL_SEQ_TIMEOUT_EN defined -> timeout_err=1 after 32 WAIT_LOCK cycles and pll_rst re-pulses; without the macro, no re-pulse and timeout_err=0.
REQ-035 relock_req and lock loss in the same RUN cycle -> one PLL_RESET entry; lock_lost_count +1; 300 forced losses -> count saturates at 255.
REQ-036 Assert rst while domain_rst=3'b110 -> all outputs reach their reset values before the next refclk edge.
